// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction from execute, waits for
// its data-SRAM response, formats load data and hands the result to
// write-back. Responses that belong to flushed instructions are counted and
// dropped as they come back.
//
// Handshake: a transfer happens on a cycle where the producer's valid and the
// consumer's allowin are both high; valid does not depend on allowin.
module mem_stage #(
    parameter int SIDE_W = 180
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              exe_mem_valid,
    output logic              mem_allowin,
    input  logic [SIDE_W-1:0] exe_mem_side,
    input  logic              exe_mem_gr_we,
    input  logic [4:0]        exe_mem_dest,
    input  logic [31:0]       exe_mem_result,
    input  logic              exe_mem_mem_req,
    input  logic [4:0]        exe_mem_load_op,
    input  logic              exe_mem_ex,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    input  logic              flush,
    input  logic              wb_allowin,
    output logic              mem_wb_valid,
    output logic [SIDE_W-1:0] mem_wb_side,
    output logic              mem_wb_gr_we,
    output logic [4:0]        mem_wb_dest,
    output logic [31:0]       mem_wb_final_result,
    output logic              mem_fwd_we,
    output logic [4:0]        mem_fwd_dest,
    output logic [31:0]       mem_fwd_data,
    output logic              mem_fwd_block,
    output logic              mem_ex_out
);

    logic              mem_valid;
    logic              wait_resp;
    logic              data_buf_valid;
    logic [31:0]       data_buf;
    logic [1:0]        discard_cnt;
    logic [1:0]        discard_cnt_nx;

    logic [SIDE_W-1:0] side_r;
    logic              gr_we_r;
    logic [4:0]        dest_r;
    logic [31:0]       result_r;
    logic [4:0]        load_op_r;
    logic              ex_r;

    logic              resp_live;
    logic              resp_take;
    logic              ready_go;
    logic              leave;
    logic              capture;
    logic [31:0]       load_word;
    logic [31:0]       final_result;

    // A response with no pending discards belongs to the held instruction.
    assign resp_live    = data_sram_data_ok & (discard_cnt == 2'd0);
    assign resp_take    = resp_live & wait_resp & mem_valid;
    assign ready_go     = ~wait_resp | data_buf_valid | resp_live;
    assign mem_allowin  = ~mem_valid | (ready_go & wb_allowin);
    assign mem_wb_valid = mem_valid & ready_go;
    assign leave        = mem_wb_valid & wb_allowin;
    assign capture      = exe_mem_valid & mem_allowin & ~flush;

    // Instruction occupancy of the stage.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
        end else if (flush) begin
            mem_valid <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid <= exe_mem_valid;
        end
    end

    // Payload registers; only meaningful while mem_valid is set.
    always_ff @(posedge clk) begin
        if (capture) begin
            side_r    <= exe_mem_side;
            gr_we_r   <= exe_mem_gr_we;
            dest_r    <= exe_mem_dest;
            result_r  <= exe_mem_result;
            load_op_r <= exe_mem_load_op;
            ex_r      <= exe_mem_ex;
        end
    end

    // Outstanding-response flag for the held instruction; a new capture wins
    // over clearing because the old instruction leaves in that same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_resp <= 1'b0;
        end else if (flush) begin
            wait_resp <= 1'b0;
        end else if (capture) begin
            wait_resp <= exe_mem_mem_req;
        end else if (resp_take) begin
            wait_resp <= 1'b0;
        end
    end

    // Park response data when write-back cannot take it in the arrival cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_buf_valid <= 1'b0;
        end else if (flush || leave) begin
            data_buf_valid <= 1'b0;
        end else if (resp_take && !wb_allowin) begin
            data_buf_valid <= 1'b1;
        end
        if (resp_take && !wb_allowin) begin
            data_buf <= data_sram_rdata;
        end
    end

    // Count of responses still to come back for killed requests.
    always_comb begin
        logic [1:0] inc;
        logic       kill_wait;
        logic       kill_new;
        logic       drop;
        kill_wait = mem_valid & wait_resp & ~resp_live;
        kill_new  = exe_mem_valid & exe_mem_mem_req & mem_allowin;
        drop      = data_sram_data_ok & (discard_cnt != 2'd0);
        inc       = 2'd0;
        if (flush) begin
            inc = {1'b0, kill_wait} + {1'b0, kill_new};
        end
        discard_cnt_nx = discard_cnt + inc - {1'b0, drop};
    end

    // Discard counter register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            discard_cnt <= 2'd0;
        end else begin
            discard_cnt <= discard_cnt_nx;
        end
    end

    // Load formatting: select lane by address, then sign/zero extend.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        load_word = resp_live ? data_sram_rdata : data_buf;
        case (result_r[1:0])
            2'd0:    lane_b = load_word[7:0];
            2'd1:    lane_b = load_word[15:8];
            2'd2:    lane_b = load_word[23:16];
            default: lane_b = load_word[31:24];
        endcase
        lane_h = result_r[1] ? load_word[31:16] : load_word[15:0];
        case (1'b1)
            load_op_r[4]: final_result = load_word;
            load_op_r[3]: final_result = {{16{lane_h[15]}}, lane_h};
            load_op_r[2]: final_result = {16'd0, lane_h};
            load_op_r[1]: final_result = {{24{lane_b[7]}}, lane_b};
            load_op_r[0]: final_result = {24'd0, lane_b};
            default:      final_result = result_r;
        endcase
    end

    assign mem_wb_side         = side_r;
    assign mem_wb_gr_we        = gr_we_r;
    assign mem_wb_dest         = dest_r;
    assign mem_wb_final_result = final_result;
    assign mem_fwd_we          = mem_valid & gr_we_r & ~ex_r;
    assign mem_fwd_dest        = dest_r;
    assign mem_fwd_data        = final_result;
    assign mem_fwd_block       = mem_valid & (load_op_r != 5'd0) & ~ready_go;
    assign mem_ex_out          = mem_valid & ex_r;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations plus a
// short random phase, all checked every cycle against a transaction-level
// model that tracks the held instruction and a queue of in-flight responses.
module tb_mem_stage;

    localparam int SIDE_W = 180;

    logic              clk;
    logic              resetn;
    logic              exe_mem_valid;
    logic              mem_allowin;
    logic [SIDE_W-1:0] exe_mem_side;
    logic              exe_mem_gr_we;
    logic [4:0]        exe_mem_dest;
    logic [31:0]       exe_mem_result;
    logic              exe_mem_mem_req;
    logic [4:0]        exe_mem_load_op;
    logic              exe_mem_ex;
    logic              data_sram_data_ok;
    logic [31:0]       data_sram_rdata;
    logic              flush;
    logic              wb_allowin;
    logic              mem_wb_valid;
    logic [SIDE_W-1:0] mem_wb_side;
    logic              mem_wb_gr_we;
    logic [4:0]        mem_wb_dest;
    logic [31:0]       mem_wb_final_result;
    logic              mem_fwd_we;
    logic [4:0]        mem_fwd_dest;
    logic [31:0]       mem_fwd_data;
    logic              mem_fwd_block;
    logic              mem_ex_out;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] LD_W  = 5'b10000;
    localparam logic [4:0] LD_H  = 5'b01000;
    localparam logic [4:0] LD_HU = 5'b00100;
    localparam logic [4:0] LD_B  = 5'b00010;
    localparam logic [4:0] LD_BU = 5'b00001;

    mem_stage #(.SIDE_W(SIDE_W)) dut (
        .clk(clk), .resetn(resetn),
        .exe_mem_valid(exe_mem_valid), .mem_allowin(mem_allowin),
        .exe_mem_side(exe_mem_side), .exe_mem_gr_we(exe_mem_gr_we),
        .exe_mem_dest(exe_mem_dest), .exe_mem_result(exe_mem_result),
        .exe_mem_mem_req(exe_mem_mem_req), .exe_mem_load_op(exe_mem_load_op),
        .exe_mem_ex(exe_mem_ex), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .flush(flush), .wb_allowin(wb_allowin),
        .mem_wb_valid(mem_wb_valid), .mem_wb_side(mem_wb_side),
        .mem_wb_gr_we(mem_wb_gr_we), .mem_wb_dest(mem_wb_dest),
        .mem_wb_final_result(mem_wb_final_result), .mem_fwd_we(mem_fwd_we),
        .mem_fwd_dest(mem_fwd_dest), .mem_fwd_data(mem_fwd_data),
        .mem_fwd_block(mem_fwd_block), .mem_ex_out(mem_ex_out)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One held instruction plus a FIFO of in-flight responses; each entry
    // is 1 when its owner is still alive, 0 when it was killed by a flush.
    bit                m_v;
    bit                started;
    logic [SIDE_W-1:0] m_side;
    logic              m_gr_we;
    logic [4:0]        m_dest;
    logic [31:0]       m_res;
    logic [4:0]        m_lop;
    logic              m_ex;
    logic              m_req;
    bit                m_got;
    logic [31:0]       m_data;
    bit                resp_q[$];

    function automatic logic [31:0] fmt(input logic [4:0] lop, input logic [31:0] addr,
                                        input logic [31:0] w);
        logic [31:0] sh;
        case (lop)
            LD_W:  return w;
            LD_H:  begin sh = w >> (16 * addr[1]); return 32'($signed(sh[15:0])); end
            LD_HU: begin sh = w >> (16 * addr[1]); return {16'd0, sh[15:0]}; end
            LD_B:  begin sh = w >> (8 * addr[1:0]); return 32'($signed(sh[7:0])); end
            LD_BU: begin sh = w >> (8 * addr[1:0]); return {24'd0, sh[7:0]}; end
            default: return addr;
        endcase
    endfunction

    function automatic bit front_alive();
        return data_sram_data_ok && resp_q.size() > 0 && resp_q[0];
    endfunction

    function automatic bit m_ready();
        return !(m_v && m_req && !m_got) || front_alive();
    endfunction

    function automatic int dead_count();
        int n = 0;
        foreach (resp_q[i]) if (!resp_q[i]) n++;
        return n;
    endfunction

    // Model state advance on each rising edge.
    always @(posedge clk) begin
        if (!resetn) begin
            m_v = 1'b0;
            m_got = 1'b0;
            resp_q.delete();
            started = 1'b1;
        end else if (started) begin
            bit rdy;
            bit allow;
            rdy   = m_ready();
            allow = !m_v || (rdy && wb_allowin);
            if (data_sram_data_ok && resp_q.size() > 0) begin
                if (resp_q[0]) begin
                    m_got  = 1'b1;
                    m_data = data_sram_rdata;
                end
                void'(resp_q.pop_front());
            end
            if (flush) foreach (resp_q[i]) resp_q[i] = 1'b0;
            if (exe_mem_valid && allow) begin
                if (exe_mem_mem_req) resp_q.push_back(!flush);
                if (!flush) begin
                    m_side  = exe_mem_side;
                    m_gr_we = exe_mem_gr_we;
                    m_dest  = exe_mem_dest;
                    m_res   = exe_mem_result;
                    m_lop   = exe_mem_load_op;
                    m_ex    = exe_mem_ex;
                    m_req   = exe_mem_mem_req;
                    m_got   = 1'b0;
                end
            end
            if (flush) m_v = 1'b0;
            else if (allow) m_v = exe_mem_valid;
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (started) begin
            bit rdy;
            logic [31:0] word;
            logic [31:0] exp_res;
            rdy  = m_ready();
            word = front_alive() ? data_sram_rdata : m_data;
            exp_res = fmt(m_lop, m_res, word);
            check("m_allowin", mem_allowin, !m_v || (rdy && wb_allowin));
            check("m_wb_valid", mem_wb_valid, m_v && rdy);
            check("m_fwd_we", mem_fwd_we, m_v && m_gr_we && !m_ex);
            check("m_fwd_block", mem_fwd_block, m_v && m_lop != 5'd0 && !rdy);
            check("m_ex_out", mem_ex_out, m_v && m_ex);
            check("m_discard_cnt", dut.discard_cnt, dead_count());
            check("discard_below_3", dut.discard_cnt != 2'd3, 1);
            if (m_v) begin
                check("m_dest", mem_wb_dest, m_dest);
                check("m_fwd_dest", mem_fwd_dest, m_dest);
                check("m_gr_we", mem_wb_gr_we, m_gr_we);
                check("m_side", mem_wb_side == m_side, 1);
                if (rdy && (m_lop == 5'd0 || !m_req || m_got || front_alive())) begin
                    check("m_final", mem_wb_final_result, exp_res);
                    check("m_fwd_data", mem_fwd_data, exp_res);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] lop, input logic [31:0] res, input logic req,
                         input logic ex, input logic we, input logic [4:0] dest);
        exe_mem_valid   = 1'b1;
        exe_mem_load_op = lop;
        exe_mem_result  = res;
        exe_mem_mem_req = req;
        exe_mem_ex      = ex;
        exe_mem_gr_we   = we;
        exe_mem_dest    = dest;
        for (int i = 0; i < SIDE_W; i++) exe_mem_side[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_exe();
        exe_mem_valid   = 1'b0;
        exe_mem_mem_req = 1'b0;
    endtask

    task automatic resp(input logic [31:0] d);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = d;
    endtask

    task automatic no_resp();
        data_sram_data_ok = 1'b0;
    endtask

    // ---------------- directed stimulus and random phase ----------------
    initial begin
        resetn = 1'b0;
        flush = 1'b0;
        wb_allowin = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'd0;
        exe_mem_side = '0;
        exe_mem_result = 32'd0;
        exe_mem_load_op = 5'd0;
        exe_mem_gr_we = 1'b0;
        exe_mem_dest = 5'd0;
        exe_mem_ex = 1'b0;
        idle_exe();
        step();
        step();
        resetn = 1'b1;
        @(negedge clk);
        check("rst_wb_valid", mem_wb_valid, 0);
        check("rst_allowin", mem_allowin, 1);
        check("rst_ex_out", mem_ex_out, 0);

        // Reset in the middle of a pending load.
        offer(LD_W, 32'h0000_0100, 1, 0, 1, 5'd1);
        step();
        idle_exe();
        @(negedge clk);
        check("pend_block", mem_fwd_block, 1);
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        @(negedge clk);
        check("rstmid_wb_valid", mem_wb_valid, 0);
        check("rstmid_discard", dut.discard_cnt, 0);
        step();
        resp(32'hCAFE_F00D);
        @(negedge clk);
        check("stray_ok_wb_valid", mem_wb_valid, 0);
        step();
        no_resp();

        // ld.b from byte 3, response two cycles after capture.
        offer(LD_B, 32'h0000_1003, 1, 0, 1, 5'd5);
        step();
        idle_exe();
        @(negedge clk);
        check("ldb_block", mem_fwd_block, 1);
        check("ldb_wait_valid", mem_wb_valid, 0);
        step();
        resp(32'h80FF_1234);
        @(negedge clk);
        check("ldb_wb_valid", mem_wb_valid, 1);
        check("ldb_result", mem_wb_final_result, 32'hFFFF_FF80);
        check("ldb_block_off", mem_fwd_block, 0);
        step();
        no_resp();
        @(negedge clk);
        check("ldb_gone", mem_wb_valid, 0);

        // ld.hu upper half, write-back stalls at response time.
        offer(LD_HU, 32'h0000_2002, 1, 0, 1, 5'd6);
        step();
        idle_exe();
        step();
        resp(32'h89AB_CDEF);
        wb_allowin = 1'b0;
        @(negedge clk);
        check("ldhu_offer", mem_wb_valid, 1);
        check("ldhu_allowin", mem_allowin, 0);
        step();
        no_resp();
        wb_allowin = 1'b1;
        @(negedge clk);
        check("ldhu_buf_valid", mem_wb_valid, 1);
        check("ldhu_result", mem_wb_final_result, 32'h0000_89AB);
        step();
        @(negedge clk);
        check("ldhu_once", mem_wb_valid, 0);

        // Plain ALU op.
        offer(5'd0, 32'h0000_0007, 0, 0, 1, 5'd3);
        step();
        idle_exe();
        @(negedge clk);
        check("add_valid", mem_wb_valid, 1);
        check("add_result", mem_wb_final_result, 32'h0000_0007);
        check("add_fwd_we", mem_fwd_we, 1);
        step();

        // Flush a waiting load, then kill a store entering behind it.
        offer(LD_W, 32'h0000_3000, 1, 0, 1, 5'd4);
        step();
        idle_exe();
        @(negedge clk);
        check("fl_wait_block", mem_fwd_block, 1);
        step();
        flush = 1'b1;
        offer(5'd0, 32'h0000_3100, 1, 0, 0, 5'd0);
        step();
        @(negedge clk);
        check("fl_cnt1", dut.discard_cnt, 1);
        step();
        flush = 1'b0;
        offer(LD_W, 32'h0000_4000, 1, 0, 1, 5'd7);
        @(negedge clk);
        check("fl_cnt2", dut.discard_cnt, 2);
        check("fl_valid0", mem_wb_valid, 0);
        step();
        idle_exe();
        resp(32'hDEAD_0001);
        @(negedge clk);
        check("fl_drop1", mem_wb_valid, 0);
        step();
        resp(32'hDEAD_0002);
        @(negedge clk);
        check("fl_drop2", mem_wb_valid, 0);
        check("fl_cnt_dec", dut.discard_cnt, 1);
        step();
        resp(32'h1234_5678);
        @(negedge clk);
        check("fl_third_valid", mem_wb_valid, 1);
        check("fl_third_result", mem_wb_final_result, 32'h1234_5678);
        step();
        no_resp();

        // Exception-tagged instruction goes straight through.
        offer(5'd0, 32'h0000_0055, 0, 1, 1, 5'd9);
        step();
        idle_exe();
        @(negedge clk);
        check("ex_out", mem_ex_out, 1);
        check("ex_fwd_we", mem_fwd_we, 0);
        check("ex_valid", mem_wb_valid, 1);
        step();

        // Back-to-back: leave and enter in the same cycle.
        offer(LD_W, 32'h0000_5000, 1, 0, 1, 5'd10);
        step();
        offer(LD_BU, 32'h0000_5001, 1, 0, 1, 5'd11);
        resp(32'hA1B2_C3D4);
        @(negedge clk);
        check("b2b_first", mem_wb_final_result, 32'hA1B2_C3D4);
        check("b2b_allowin", mem_allowin, 1);
        step();
        idle_exe();
        resp(32'h0000_7F00);
        @(negedge clk);
        check("b2b_second_valid", mem_wb_valid, 1);
        check("b2b_second", mem_wb_final_result, 32'h0000_007F);
        step();
        no_resp();
        step();

        // Random mix checked by the model only.
        for (int c = 0; c < 400; c++) begin
            logic [4:0] lop;
            logic       req;
            wb_allowin = ($urandom_range(0, 3) != 0);
            data_sram_data_ok = (resp_q.size() > 0) && ($urandom_range(0, 1) == 1);
            data_sram_rdata = $urandom();
            flush = (resp_q.size() <= 1) && ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 5))
                    0: lop = LD_W;
                    1: lop = LD_H;
                    2: lop = LD_HU;
                    3: lop = LD_B;
                    4: lop = LD_BU;
                    default: lop = 5'd0;
                endcase
                req = (lop != 5'd0) || ($urandom_range(0, 1) == 1);
                offer(lop, $urandom(), req, req ? 1'b0 : 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            end else begin
                idle_exe();
            end
            step();
        end
        flush = 1'b0;
        idle_exe();
        no_resp();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
